// File: rtl/lcd_text_driver.sv
// -----------------------------------------------------------------------------
// lcd_text_driver
//
// Drives an HD44780-style character LCD over its 8-bit parallel bus. It shows
// two 16-character text lines supplied by the active display mode.
//
// After reset the driver waits for the panel to power up. It then runs the
// init command sequence. After that it refreshes both rows continuously.
//
// Every byte write takes three cycles:
//   SETUP : e=0, rs/data take the new byte
//   PULSE : e=1
//   HOLD  : e=0, rs/data held
// This means e can never be high on two consecutive cycles.
//
// Both input lines are copied into internal buffers during the SETUP cycle of
// each frame's 8'h80 command. A frame therefore always shows one consistent
// snapshot of the text.
//
// Ports
//   clk_1kHz      in   1    system clock (1 ms period)
//   i_rst_n       in   1    asynchronous reset, active low
//   i_line1       in   128  row-1 text, char k at [127-8k -: 8]
//   i_line2       in   128  row-2 text, same packing
//   o_lcd_e       out  1    LCD enable strobe
//   o_lcd_rs      out  1    0 = command, 1 = data
//   o_lcd_rw      out  1    always 0 (write-only)
//   o_lcd_data    out  8    LCD data bus
//   o_init_done   out  1    high once the init sequence has completed
//   o_frame_done  out  1    one-cycle pulse in the HOLD of the last row-2 char
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module lcd_text_driver #(
    parameter int POWER_ON_WAIT = 20,
    parameter int CLEAR_WAIT    = 2,
    parameter int REFRESH_GAP   = 0
) (
    input  logic         clk_1kHz,
    input  logic         i_rst_n,
    input  logic [127:0] i_line1,
    input  logic [127:0] i_line2,
    output logic         o_lcd_e,
    output logic         o_lcd_rs,
    output logic         o_lcd_rw,
    output logic [7:0]   o_lcd_data,
    output logic         o_init_done,
    output logic         o_frame_done
);

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_INIT,
        ST_CLR_WAIT,
        ST_FRAME,
        ST_GAP
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_PULSE,
        PH_HOLD
    } phase_t;

    // Terminal counts for the idle waits. The counter runs from 0 to N-1.
    localparam logic [15:0] PWR_LAST = 16'(POWER_ON_WAIT - 1);
    localparam logic [15:0] CLR_LAST = 16'(CLEAR_WAIT - 1);
    localparam logic [15:0] GAP_LAST = 16'(REFRESH_GAP - 1);

    state_t       r_state;
    phase_t       r_phase;
    logic [1:0]   r_init_idx;
    logic [15:0]  r_cnt;
    logic         r_row;        // 0 = row 1, 1 = row 2
    logic         r_cmd;        // current write is the row-address command
    logic [3:0]   r_char;       // char index within the row; wraps 15 -> 0
    logic [127:0] r_buf1;
    logic [127:0] r_buf2;
    logic         r_e;
    logic         r_rs;
    logic [7:0]   r_data;
    logic         r_init_done;
    logic         r_frame_done;

    logic [127:0] w_cur_buf;
    logic [3:0]   w_next_idx;
    logic [7:0]   w_next_char;
    logic         w_last_char;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;   // 8-bit bus, 2 lines
            2'd1:    return 8'h0C;   // display on, cursor off
            2'd2:    return 8'h01;   // clear
            default: return 8'h06;   // entry mode: increment
        endcase
    endfunction

    function automatic logic [7:0] char_of(input logic [127:0] line, input logic [3:0] idx);
        return line[(7'd127 - {idx, 3'b000}) -: 8];
    endfunction

    // Finds the character that follows the current write in the same row.
    // After the row command this is char 0. Otherwise it is the next index.
    assign w_cur_buf   = r_row ? r_buf2 : r_buf1;
    assign w_next_idx  = r_cmd ? 4'd0 : r_char + 4'd1;
    assign w_next_char = char_of(w_cur_buf, w_next_idx);
    assign w_last_char = r_row & ~r_cmd & (r_char == 4'd15);

    always_ff @(posedge clk_1kHz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_PWR_WAIT;
            r_phase      <= PH_SETUP;
            r_init_idx   <= 2'd0;
            r_cnt        <= 16'd0;
            r_row        <= 1'b0;
            r_cmd        <= 1'b0;
            r_char       <= 4'd0;
            r_buf1       <= '0;
            r_buf2       <= '0;
            r_e          <= 1'b0;
            r_rs         <= 1'b0;
            r_data       <= 8'h00;
            r_init_done  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_PWR_WAIT: begin
                    if (r_cnt == PWR_LAST) begin
                        r_cnt      <= 16'd0;
                        r_state    <= ST_INIT;
                        r_phase    <= PH_SETUP;
                        r_init_idx <= 2'd0;
                        r_rs       <= 1'b0;
                        r_data     <= init_byte(2'd0);
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                ST_INIT: begin
                    case (r_phase)
                        PH_SETUP: begin
                            r_e     <= 1'b1;
                            r_phase <= PH_PULSE;
                        end
                        PH_PULSE: begin
                            r_e     <= 1'b0;
                            r_phase <= PH_HOLD;
                        end
                        default: begin
                            if (r_init_idx == 2'd3) begin
                                // Init is complete. Go straight into the first frame.
                                r_init_done <= 1'b1;
                                r_state     <= ST_FRAME;
                                r_phase     <= PH_SETUP;
                                r_row       <= 1'b0;
                                r_cmd       <= 1'b1;
                                r_char      <= 4'd0;
                                r_rs        <= 1'b0;
                                r_data      <= 8'h80;
                            end else if (r_init_idx == 2'd2 && CLEAR_WAIT != 0) begin
                                // The clear command needs extra settling time.
                                r_state <= ST_CLR_WAIT;
                                r_cnt   <= 16'd0;
                            end else begin
                                r_init_idx <= r_init_idx + 2'd1;
                                r_phase    <= PH_SETUP;
                                r_data     <= init_byte(r_init_idx + 2'd1);
                            end
                        end
                    endcase
                end

                ST_CLR_WAIT: begin
                    if (r_cnt == CLR_LAST) begin
                        r_cnt      <= 16'd0;
                        r_state    <= ST_INIT;
                        r_phase    <= PH_SETUP;
                        r_init_idx <= 2'd3;
                        r_data     <= init_byte(2'd3);
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                ST_FRAME: begin
                    case (r_phase)
                        PH_SETUP: begin
                            if (!r_row && r_cmd) begin
                                r_buf1 <= i_line1;
                                r_buf2 <= i_line2;
                            end
                            r_e     <= 1'b1;
                            r_phase <= PH_PULSE;
                        end
                        PH_PULSE: begin
                            r_e          <= 1'b0;
                            r_phase      <= PH_HOLD;
                            r_frame_done <= w_last_char;
                        end
                        default: begin
                            if (w_last_char) begin
                                if (REFRESH_GAP == 0) begin
                                    r_phase <= PH_SETUP;
                                    r_row   <= 1'b0;
                                    r_cmd   <= 1'b1;
                                    r_char  <= 4'd0;
                                    r_rs    <= 1'b0;
                                    r_data  <= 8'h80;
                                end else begin
                                    r_state <= ST_GAP;
                                    r_cnt   <= 16'd0;
                                end
                            end else if (!r_cmd && r_char == 4'd15) begin
                                // End of row 1: the index wraps and row 2 starts with its address command.
                                r_phase <= PH_SETUP;
                                r_row   <= 1'b1;
                                r_cmd   <= 1'b1;
                                r_char  <= 4'd0;
                                r_rs    <= 1'b0;
                                r_data  <= 8'hC0;
                            end else begin
                                r_phase <= PH_SETUP;
                                r_cmd   <= 1'b0;
                                r_char  <= w_next_idx;
                                r_rs    <= 1'b1;
                                r_data  <= w_next_char;
                            end
                        end
                    endcase
                end

                ST_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt   <= 16'd0;
                        r_state <= ST_FRAME;
                        r_phase <= PH_SETUP;
                        r_row   <= 1'b0;
                        r_cmd   <= 1'b1;
                        r_char  <= 4'd0;
                        r_rs    <= 1'b0;
                        r_data  <= 8'h80;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                default: begin
                    r_state <= ST_PWR_WAIT;
                    r_cnt   <= 16'd0;
                end
            endcase
        end
    end

    assign o_lcd_e      = r_e;
    assign o_lcd_rs     = r_rs;
    assign o_lcd_rw     = 1'b0;
    assign o_lcd_data   = r_data;
    assign o_init_done  = r_init_done;
    assign o_frame_done = r_frame_done;

endmodule
